pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register (IF/ID, ID/EX, ...) with valid/allow_in handshake, hold and flush.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 20 ++
 rtl/pipe_stage_skid.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: one-hot stage states, the RV32I NOP
// bubble and the packed entry width helper.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'b001,
    ST_PIPE  = 3'b010,
    ST_FULL  = 3'b100
  } pipe_state_e;

  localparam logic [31:0] BUBBLE_NOP = 32'h0000_0013;

  localparam int unsigned HS_W = 1;

  // Head and skid store pc and data packed together, pc in the upper bits.
  function automatic int unsigned entry_width(input int unsigned pc_w, input int unsigned data_w);
    return pc_w + data_w;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (packed pc + data) with load enable and asynchronous active-high reset.
module pipe_entry_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/allow_in handshake, hold, flush and optional skid entry.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       PC_W   = 32,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              valid_prev,
  input  logic              ready_go_prev,
  input  logic [PC_W-1:0]   pc_prev,
  input  logic [DATA_W-1:0] data_prev,
  output logic              allow_in,
  input  logic              allow_in_next,
  output logic              out_valid,
  output logic              out_ready_go,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned ENTRY_W = entry_width(PC_W, DATA_W);

  pipe_state_e        state_q;
  logic               st_empty;
  logic               st_pipe;
  logic               st_full;
  logic               acc;
  logic               com;
  logic               head_load;
  logic               skid_load;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_d;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] skid_q;

  assign st_empty = (state_q == ST_EMPTY);
  assign st_pipe  = (state_q == ST_PIPE);
  assign st_full  = (state_q == ST_FULL);

  assign out_valid    = !st_empty;
  assign out_ready_go = !hold;
  assign com          = out_valid && !hold && allow_in_next;

  // With a skid entry allow_in depends on state only, which breaks the backward comb. path.
  if (DEPTH == 2) begin : g_allow_reg
    assign allow_in = !st_full;
  end else begin : g_allow_comb
    assign allow_in = st_empty || com;
  end

  assign acc      = valid_prev && ready_go_prev && allow_in && !flush;
  assign in_entry = {pc_prev, data_prev};

  // Head takes new data when it is (or becomes) free; in FULL it is refilled from the skid.
  assign head_load = !flush && ((st_empty && acc) || (st_pipe && acc && com) || (st_full && com));
  assign skid_load = (DEPTH == 2) && st_pipe && acc && !com;
  assign head_d    = st_full ? skid_q : in_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_q <= ST_PIPE;
          end
        end
        ST_PIPE: begin
          if (acc && !com) begin
            state_q <= (DEPTH == 2) ? ST_FULL : ST_PIPE;
          end else if (!acc && com) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (com) begin
            state_q <= ST_PIPE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(
    .W (ENTRY_W)
  ) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  if (DEPTH == 2) begin : g_skid
    pipe_entry_reg #(
      .W (ENTRY_W)
    ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (in_entry),
      .q    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = '0;
  end

  assign out_pc   = out_valid ? head_q[ENTRY_W-1 -: PC_W] : '0;
  assign out_data = out_valid ? head_q[DATA_W-1:0] : BUBBLE;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !com && !flush) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && !st_empty) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: DEPTH=2 and DEPTH=1 stages share stimulus; each has a queue-based model.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        valid_prev = 1'b0;
  logic        ready_go_prev = 1'b0;
  logic [31:0] pc_prev = '0;
  logic [31:0] data_prev = '0;
  logic        allow_in_next = 1'b0;

  logic        allow_in2, out_valid2, out_ready_go2;
  logic [31:0] out_pc2, out_data2;
  logic        allow_in1, out_valid1, out_ready_go1;
  logic [31:0] out_pc1, out_data1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt2, flush_cnt2, stall_cnt1, flush_cnt1;
  logic [31:0] m_stall2 = '0, m_flush2 = '0, m_stall1 = '0, m_flush1 = '0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ent_t q2[$];
  ent_t q1[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.PC_W(32), .DATA_W(32), .DEPTH(2), .BUBBLE(NOP)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .hold          (hold),
    .valid_prev    (valid_prev),
    .ready_go_prev (ready_go_prev),
    .pc_prev       (pc_prev),
    .data_prev     (data_prev),
    .allow_in      (allow_in2),
    .allow_in_next (allow_in_next),
    .out_valid     (out_valid2),
    .out_ready_go  (out_ready_go2),
    .out_pc        (out_pc2),
    .out_data      (out_data2)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt     (stall_cnt2),
    .flush_cnt     (flush_cnt2)
`endif
  );

  pipe_stage_skid #(.PC_W(32), .DATA_W(32), .DEPTH(1), .BUBBLE(NOP)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .hold          (hold),
    .valid_prev    (valid_prev),
    .ready_go_prev (ready_go_prev),
    .pc_prev       (pc_prev),
    .data_prev     (data_prev),
    .allow_in      (allow_in1),
    .allow_in_next (allow_in_next),
    .out_valid     (out_valid1),
    .out_ready_go  (out_ready_go1),
    .out_pc        (out_pc1),
    .out_data      (out_data1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt     (stall_cnt1),
    .flush_cnt     (flush_cnt1)
`endif
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endfunction

  // Monitor + reference model: a stage is a FIFO of capacity DEPTH.
  always @(negedge clk) begin : mon
    logic ea2, ea1, c2, c1, a2, a1;
    if (rst) begin
      q2.delete();
      q1.delete();
`ifdef PIPE_STAGE_PERF_EN
      m_stall2 = '0; m_flush2 = '0; m_stall1 = '0; m_flush1 = '0;
`endif
    end
    c2  = (q2.size() != 0) && !hold && allow_in_next;
    c1  = (q1.size() != 0) && !hold && allow_in_next;
    ea2 = q2.size() < 2;
    ea1 = (q1.size() == 0) || c1;
    a2  = valid_prev && ready_go_prev && ea2 && !flush;
    a1  = valid_prev && ready_go_prev && ea1 && !flush;

    check("d2_out_valid", 64'(out_valid2), 64'(q2.size() != 0));
    check("d2_allow_in", 64'(allow_in2), 64'(ea2));
    check("d2_ready_go", 64'(out_ready_go2), 64'(!hold));
    check("d1_out_valid", 64'(out_valid1), 64'(q1.size() != 0));
    check("d1_allow_in", 64'(allow_in1), 64'(ea1));
    check("d1_ready_go", 64'(out_ready_go1), 64'(!hold));
    if (q2.size() != 0) begin
      check("d2_out_pc", 64'(out_pc2), 64'(q2[0].pc));
      check("d2_out_data", 64'(out_data2), 64'(q2[0].data));
    end else begin
      check("d2_empty_pc", 64'(out_pc2), 64'd0);
      check("d2_bubble", 64'(out_data2), 64'(NOP));
    end
    if (q1.size() != 0) begin
      check("d1_out_pc", 64'(out_pc1), 64'(q1[0].pc));
      check("d1_out_data", 64'(out_data1), 64'(q1[0].data));
    end else begin
      check("d1_empty_pc", 64'(out_pc1), 64'd0);
      check("d1_bubble", 64'(out_data1), 64'(NOP));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("d2_stall_cnt", 64'(stall_cnt2), 64'(m_stall2));
    check("d2_flush_cnt", 64'(flush_cnt2), 64'(m_flush2));
    check("d1_stall_cnt", 64'(stall_cnt1), 64'(m_stall1));
    check("d1_flush_cnt", 64'(flush_cnt1), 64'(m_flush1));
    if (!rst) begin
      m_stall2 += 32'((q2.size() != 0) && !c2 && !flush);
      m_flush2 += 32'(flush && (q2.size() != 0));
      m_stall1 += 32'((q1.size() != 0) && !c1 && !flush);
      m_flush1 += 32'(flush && (q1.size() != 0));
    end
`endif
    if (!rst) begin
      if (flush) begin
        q2.delete();
        q1.delete();
      end else begin
        if (c2) void'(q2.pop_front());
        if (c1) void'(q1.pop_front());
        if (a2) q2.push_back('{pc: pc_prev, data: data_prev});
        if (a1) q1.push_back('{pc: pc_prev, data: data_prev});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic nxt,
                       input logic h, input logic f);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    valid_prev    = v;
    ready_go_prev = 1'b1;
    pc_prev       = pc;
    data_prev     = $urandom;
    allow_in_next = nxt;
    hold          = h;
    flush         = f;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    // Stream back-to-back
    drive(1, 32'h0, 1, 0, 0);
    drive(1, 32'h4, 1, 0, 0);
    drive(1, 32'h8, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    // Skid fill then drain
    drive(1, 32'h10, 1, 0, 0);
    drive(1, 32'h14, 0, 0, 0);
    drive(0, 32'h18, 0, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    // Flush while full with a concurrent valid input
    drive(1, 32'h20, 0, 0, 0);
    drive(1, 32'h24, 0, 0, 0);
    drive(1, 32'h28, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0);
    // Hold for three cycles (also yields four stall cycles before the flush below)
    drive(1, 32'h30, 1, 0, 0);
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0);
    // Async reset in the middle of a cycle while full
    drive(1, 32'h40, 0, 0, 0);
    drive(1, 32'h44, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid2), 64'd0);
    check("rst_allow_in", 64'(allow_in2), 64'd1);
    check("rst_out_data", 64'(out_data2), 64'(NOP));
    check("rst_out_pc", 64'(out_pc2), 64'd0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 31) == 0));
      ready_go_prev = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
      end
    end
    drive(0, 32'h0, 1, 0, 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
